// File: rtl/pc_sequencer.sv
// Program-counter unit for the fetch stage: PC register, next-PC selection with redirect priority,
// halt/resume control, redirect alignment checking and a fetch-valid qualifier.
module pc_sequencer #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      INC      = 4,
    parameter int unsigned      SHIFT    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(32'h0000_0080)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchOffset,
    input  logic             JumpEn,
    input  logic [25:0]      JumpIndex,
    input  logic             JrEn,
    input  logic [WIDTH-1:0] JrTarget,
    input  logic             Halt,
    input  logic             Resume,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlusInc,
    output logic [WIDTH-1:0] BranchTarget,
    output logic             FetchValid,
    output logic             MisalignFault
);

    // INC is a power of two, so INC-1 masks the bits that must be zero in a redirect target.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             fault_q, fault_d;

    logic [WIDTH-1:0] pc_plus_inc;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] redirect_target;
    logic             redirect;
    logic             misaligned;

    assign pc_plus_inc   = pc_q + WIDTH'(INC);
    assign branch_target = pc_plus_inc + (BranchOffset << SHIFT);
    assign jump_target   = {pc_plus_inc[WIDTH-1:28], JumpIndex, 2'b00};

    always_comb begin
        redirect        = JrEn | JumpEn | BranchTaken;
        redirect_target = branch_target;
        if (JrEn) begin
            redirect_target = JrTarget;
        end else if (JumpEn) begin
            redirect_target = jump_target;
        end
    end

    assign misaligned = |(redirect_target & ALIGN_MASK);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        fault_d       = fault_q;
        unique case (state_q)
            StBoot: begin
                state_d       = StRun;
                fetch_valid_d = 1'b1;
            end
            StRun: begin
                // A stalled cycle drops any redirect; the requester must assert it again.
                if (!Stall) begin
                    if (redirect) begin
                        if (misaligned) begin
                            pc_d    = TRAP_VEC;
                            fault_d = 1'b1;
                        end else begin
                            pc_d = redirect_target;
                        end
                    end else begin
                        pc_d = pc_plus_inc;
                    end
                end
                if (Halt) begin
                    state_d       = StHalt;
                    fetch_valid_d = 1'b0;
                end
            end
            StHalt: begin
                if (Resume && !Halt) begin
                    state_d       = StRun;
                    fetch_valid_d = 1'b1;
                end
            end
            default: begin
                state_d       = StBoot;
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign PC            = pc_q;
    assign PCPlusInc     = pc_plus_inc;
    assign BranchTarget  = branch_target;
    assign FetchValid    = fetch_valid_q;
    assign MisalignFault = fault_q;

endmodule
